soml_frame_buffer: RTL

Parametrised, double-buffered (ping-pong) input front-end for the SOML decoder. It captures one frame (channel matrix H of NR x NT complex words plus NY complex Y samples) into one bank while the downstream Hq/trace pipeline reads the other bank. This lets frame k+1 load while frame k is being decoded. It sits between the sample interface and matrix_multiplier/trace_calculator, replacing the single-bank load FSM in the decoder top.

---
 rtl/soml_frame_buffer_if.sv | 57 +++++
 rtl/soml_frame_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/soml_frame_buffer_if.sv
// Sample/consumer bus of the SOML ping-pong frame buffer.
// Valid/ready semantics: a beat on H_in_valid or Y_in_valid counts only while
// the loader is loading and that stream still needs data. Beats offered at any
// other time are dropped and flagged on proto_err. start is honoured only when
// load_ready is high. calc_start is a one-cycle offer of a full bank, and
// calc_done hands that bank back.
interface soml_frame_buffer_if #(
   parameter int N  = 32,
   parameter int NR = 4,
   parameter int NT = 4,
   parameter int NY = 8
);
   localparam int RW = (NR > 1) ? $clog2(NR) : 1;
   localparam int CW = (NT > 1) ? $clog2(NT) : 1;
   localparam int YW = (NY > 2) ? $clog2(NY / 2) : 1;

   // loader side
   logic          start;
   logic          H_in_valid;
   logic [N-1:0]  H_in_r;
   logic [N-1:0]  H_in_i;
   logic          Y_in_valid;
   logic [N-1:0]  Y_in_r;
   logic [N-1:0]  Y_in_i;
   logic          load_ready;
   logic          loading;
   // consumer side
   logic          calc_start;
   logic          calc_bank;
   logic          calc_done;
   logic [RW-1:0] rd_h_row;
   logic [CW-1:0] rd_h_col;
   logic [N-1:0]  rd_h_r;
   logic [N-1:0]  rd_h_i;
   logic          rd_y_half;
   logic [YW-1:0] rd_y_idx;
   logic [N-1:0]  rd_y_r;
   logic [N-1:0]  rd_y_i;
   // status and FSM visibility
   logic          proto_err;
   logic          dbg_load_st;   // 0 = L_IDLE, 1 = L_LOAD
   logic [3:0]    dbg_bank_st;   // {bank1, bank0}: 0 EMPTY, 1 FILLING, 2 FULL, 3 BUSY

   modport master (
      output start, H_in_valid, H_in_r, H_in_i, Y_in_valid, Y_in_r, Y_in_i,
      output calc_done, rd_h_row, rd_h_col, rd_y_half, rd_y_idx,
      input  load_ready, loading, calc_start, calc_bank,
      input  rd_h_r, rd_h_i, rd_y_r, rd_y_i, proto_err, dbg_load_st, dbg_bank_st
   );

   modport slave (
      input  start, H_in_valid, H_in_r, H_in_i, Y_in_valid, Y_in_r, Y_in_i,
      input  calc_done, rd_h_row, rd_h_col, rd_y_half, rd_y_idx,
      output load_ready, loading, calc_start, calc_bank,
      output rd_h_r, rd_h_i, rd_y_r, rd_y_i, proto_err, dbg_load_st, dbg_bank_st
   );
endinterface

// File: rtl/soml_frame_buffer.sv
// Ping-pong frame buffer for the SOML decoder: one bank loads H and Y while
// the other bank is read by the Hq/trace pipeline. NY is assumed to be a power
// of two so that {half, idx} forms the Y address directly.
module soml_frame_buffer #(
   parameter int N      = 32,
   parameter int NR     = 4,
   parameter int NT     = 4,
   parameter int NY     = 8,
   parameter bit CONJ_Y = 1'b1
) (
   input logic              clk,
   input logic              rst,
   soml_frame_buffer_if.slave bus
);

   localparam int HN  = NR * NT;
   localparam int HAW = (HN > 1) ? $clog2(HN) : 1;
   localparam int HCW = $clog2(HN + 1);
   localparam int YAW = (NY > 1) ? $clog2(NY) : 1;
   localparam int YCW = $clog2(NY + 1);
   localparam logic [HCW-1:0] H_LAST = HCW'(HN - 1);
   localparam logic [HCW-1:0] H_ALL  = HCW'(HN);
   localparam logic [YCW-1:0] Y_LAST = YCW'(NY - 1);
   localparam logic [YCW-1:0] Y_ALL  = YCW'(NY);

   typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2, B_BUSY = 2'd3} bank_st_e;
   typedef enum logic {L_IDLE = 1'b0, L_LOAD = 1'b1} load_st_e;

   load_st_e       load_st_q, load_st_d;
   bank_st_e       bank_st_q [2];
   bank_st_e       bank_st_d [2];
   logic           wr_bank_q, wr_bank_d;
   logic           calc_bank_q, calc_bank_d;
   logic [HCW-1:0] h_cnt_q, h_cnt_d;
   logic [YCW-1:0] y_cnt_q, y_cnt_d;
   logic           proto_err_q, proto_err_d;

   // Banks are flattened as {bank, address}; contents are never reset.
   logic [N-1:0] h_r_mem [2**(HAW+1)];
   logic [N-1:0] h_i_mem [2**(HAW+1)];
   logic [N-1:0] y_r_mem [2**(YAW+1)];
   logic [N-1:0] y_i_mem [2**(YAW+1)];

   logic     h_acc, y_acc, h_full_now, y_full_now, frame_done;
   logic     any_busy, disp_bank, dispatch, load_ready;
   logic     calc_bank_out;
   logic [N-1:0] y_i_wr;
   logic [HAW-1:0] rd_h_addr;

   // A beat is accepted only while loading and while its stream is short.
   // A frame completes on the cycle the second stream takes its last beat.
   always_comb begin
      h_acc      = (load_st_q == L_LOAD) && bus.H_in_valid && (h_cnt_q != H_ALL);
      y_acc      = (load_st_q == L_LOAD) && bus.Y_in_valid && (y_cnt_q != Y_ALL);
      h_full_now = (h_cnt_q == H_ALL) || (h_acc && (h_cnt_q == H_LAST));
      y_full_now = (y_cnt_q == Y_ALL) || (y_acc && (y_cnt_q == Y_LAST));
      frame_done = (load_st_q == L_LOAD) && h_full_now && y_full_now;
      any_busy   = (bank_st_q[0] == B_BUSY) || (bank_st_q[1] == B_BUSY);
      // The bank not last dispatched is the older one if it is waiting.
      disp_bank  = (bank_st_q[~calc_bank_q] == B_FULL) ? ~calc_bank_q : calc_bank_q;
      dispatch   = !any_busy && (bank_st_q[disp_bank] == B_FULL);
      load_ready = (load_st_q == L_IDLE) && (bank_st_q[wr_bank_q] == B_EMPTY);
   end

   // Next-state for the loader FSM, bank states and the consumer hand-off.
   always_comb begin
      load_st_d    = load_st_q;
      bank_st_d[0] = bank_st_q[0];
      bank_st_d[1] = bank_st_q[1];
      wr_bank_d    = wr_bank_q;
      calc_bank_d  = calc_bank_q;
      h_cnt_d      = h_cnt_q;
      y_cnt_d      = y_cnt_q;
      proto_err_d  = proto_err_q;
      case (load_st_q)
         L_IDLE: begin
            if (bus.H_in_valid || bus.Y_in_valid) proto_err_d = 1'b1;
            if (bus.start) begin
               if (load_ready) begin
                  load_st_d            = L_LOAD;
                  bank_st_d[wr_bank_q] = B_FILLING;
               end else begin
                  proto_err_d = 1'b1;
               end
            end
         end
         L_LOAD: begin
            if ((bus.H_in_valid && !h_acc) || (bus.Y_in_valid && !y_acc)) proto_err_d = 1'b1;
            h_cnt_d = h_cnt_q + {{(HCW-1){1'b0}}, h_acc};
            y_cnt_d = y_cnt_q + {{(YCW-1){1'b0}}, y_acc};
            if (frame_done) begin
               bank_st_d[wr_bank_q] = B_FULL;
               h_cnt_d              = '0;
               y_cnt_d              = '0;
               wr_bank_d            = ~wr_bank_q;
               load_st_d            = L_IDLE;
            end
         end
         default: load_st_d = L_IDLE;
      endcase
      // Dispatch needs no BUSY bank and release needs one, so they never coincide.
      if (dispatch) begin
         bank_st_d[disp_bank] = B_BUSY;
         calc_bank_d          = disp_bank;
      end
      if (bus.calc_done && (bank_st_q[calc_bank_q] == B_BUSY)) begin
         bank_st_d[calc_bank_q] = B_EMPTY;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_st_q    <= L_IDLE;
         bank_st_q[0] <= B_EMPTY;
         bank_st_q[1] <= B_EMPTY;
         wr_bank_q    <= 1'b0;
         calc_bank_q  <= 1'b0;
         h_cnt_q      <= '0;
         y_cnt_q      <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         load_st_q    <= load_st_d;
         bank_st_q[0] <= bank_st_d[0];
         bank_st_q[1] <= bank_st_d[1];
         wr_bank_q    <= wr_bank_d;
         calc_bank_q  <= calc_bank_d;
         h_cnt_q      <= h_cnt_d;
         y_cnt_q      <= y_cnt_d;
         proto_err_q  <= proto_err_d;
      end
   end

   // Conjugation is a plain two's-complement negate; the most negative value maps to itself.
   assign y_i_wr = CONJ_Y ? (-bus.Y_in_i) : bus.Y_in_i;

   // Sample RAM writes into the bank being filled.
   always_ff @(posedge clk) begin
      if (h_acc) begin
         h_r_mem[{wr_bank_q, h_cnt_q[HAW-1:0]}] <= bus.H_in_r;
         h_i_mem[{wr_bank_q, h_cnt_q[HAW-1:0]}] <= bus.H_in_i;
      end
      if (y_acc) begin
         y_r_mem[{wr_bank_q, y_cnt_q[YAW-1:0]}] <= bus.Y_in_r;
         y_i_mem[{wr_bank_q, y_cnt_q[YAW-1:0]}] <= y_i_wr;
      end
   end

   // During the calc_start cycle the consumer already sees the bank being handed over.
   assign calc_bank_out = dispatch ? disp_bank : calc_bank_q;
   assign rd_h_addr     = HAW'(bus.rd_h_row) * HAW'(NT) + HAW'(bus.rd_h_col);

   assign bus.load_ready  = load_ready;
   assign bus.loading     = (load_st_q == L_LOAD);
   assign bus.calc_start  = dispatch;
   assign bus.calc_bank   = calc_bank_out;
   assign bus.rd_h_r      = h_r_mem[{calc_bank_out, rd_h_addr}];
   assign bus.rd_h_i      = h_i_mem[{calc_bank_out, rd_h_addr}];
   assign bus.rd_y_r      = y_r_mem[{calc_bank_out, bus.rd_y_half, bus.rd_y_idx}];
   assign bus.rd_y_i      = y_i_mem[{calc_bank_out, bus.rd_y_half, bus.rd_y_idx}];
   assign bus.proto_err   = proto_err_q;
   assign bus.dbg_load_st = load_st_q;
   assign bus.dbg_bank_st = {bank_st_q[1], bank_st_q[0]};

endmodule
